// File: rtl/tmr_scrub_regfile_if.sv
// Bus bundle for the TMR register file: write, read, scrub control, fault injection, error report.
// The slave modport is the register file; the master modport is whoever drives it.
interface tmr_scrub_regfile_if #(
  parameter int DataWidth = 32,
  parameter int NumWords  = 8,
  parameter int CntWidth  = 16
);
  localparam int AddrW = $clog2(NumWords);

  logic                 wr_valid_i;
  logic                 wr_ready_o;
  logic [AddrW-1:0]     wr_addr_i;
  logic [DataWidth-1:0] wr_data_i;
  logic [AddrW-1:0]     rd_addr_i;
  logic [DataWidth-1:0] rd_data_o;
  logic                 rd_mismatch_o;
  logic                 scrub_en_i;
  logic                 inj_en_i;
  logic [1:0]           inj_copy_i;
  logic [AddrW-1:0]     inj_addr_i;
  logic [DataWidth-1:0] inj_mask_i;
  logic                 err_o;
  logic [2:0]           err_copy_o;
  logic [CntWidth-1:0]  err_cnt_o;

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, rd_addr_i, scrub_en_i,
           inj_en_i, inj_copy_i, inj_addr_i, inj_mask_i,
    output wr_ready_o, rd_data_o, rd_mismatch_o, err_o, err_copy_o, err_cnt_o
  );

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, rd_addr_i, scrub_en_i,
           inj_en_i, inj_copy_i, inj_addr_i, inj_mask_i,
    input  wr_ready_o, rd_data_o, rd_mismatch_o, err_o, err_copy_o, err_cnt_o
  );
endinterface

// File: rtl/tmr_scrub_regfile.sv
// Triplicated register file with majority-voted reads, a background scrubber that
// repairs divergent copies, and an XOR fault-injection port.
module tmr_scrub_regfile #(
  parameter int DataWidth     = 32,
  parameter int NumWords      = 8,
  parameter int ScrubInterval = 16,
  parameter int CntWidth      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  tmr_scrub_regfile_if.slave bus
);
  localparam int AddrW = $clog2(NumWords);
  localparam int IvlW  = (ScrubInterval > 1) ? $clog2(ScrubInterval) : 1;
  localparam logic [IvlW-1:0]  IvlLast = IvlW'(ScrubInterval - 1);
  localparam logic [AddrW-1:0] PtrLast = AddrW'(NumWords - 1);

  typedef enum logic [1:0] {IDLE, CHECK, FIX} state_e;
  typedef logic [NumWords-1:0][DataWidth-1:0] bank_t;

  function automatic logic [DataWidth-1:0] vote(input logic [DataWidth-1:0] a,
                                                input logic [DataWidth-1:0] b,
                                                input logic [DataWidth-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_e               r_state, w_state_nxt;
  bank_t                r_mem [3];
  bank_t                w_mem_nxt [3];
  logic [AddrW-1:0]     r_ptr;
  logic [IvlW-1:0]      r_ivl;
  logic                 r_err;
  logic [2:0]           r_err_copy;
  logic [CntWidth-1:0]  r_cnt;
  logic [DataWidth-1:0] r_fix_word;

  logic [DataWidth-1:0] w_rd [3];
  logic [DataWidth-1:0] w_sc [3];
  logic [DataWidth-1:0] w_sc_vote;
  logic [2:0]           w_sc_diff;
  logic                 w_wr_ready, w_wr_fire, w_wr_hit;
  logic                 w_chk_err, w_fix_we, w_ptr_adv;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_rd[k] = r_mem[k][bus.rd_addr_i];
      w_sc[k] = r_mem[k][r_ptr];
    end
  end

  assign w_sc_vote = vote(w_sc[0], w_sc[1], w_sc[2]);
  assign w_sc_diff = {w_sc[2] != w_sc_vote, w_sc[1] != w_sc_vote, w_sc[0] != w_sc_vote};
  assign w_wr_fire = bus.wr_valid_i && w_wr_ready;
  // A write landing on the word under check supersedes the check, so skip it.
  assign w_wr_hit  = bus.wr_valid_i && (bus.wr_addr_i == r_ptr);

  assign bus.rd_data_o     = vote(w_rd[0], w_rd[1], w_rd[2]);
  assign bus.rd_mismatch_o = (w_rd[0] != w_rd[1]) || (w_rd[0] != w_rd[2]);
  assign bus.wr_ready_o    = w_wr_ready;
  assign bus.err_o         = r_err;
  assign bus.err_copy_o    = r_err_copy;
  assign bus.err_cnt_o     = r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.scrub_en_i && r_ivl == IvlLast) w_state_nxt = CHECK;
      CHECK:   w_state_nxt = w_chk_err ? FIX : IDLE;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_wr_ready = 1'b1;
    w_chk_err  = 1'b0;
    w_fix_we   = 1'b0;
    w_ptr_adv  = 1'b0;
    case (r_state)
      CHECK: begin
        w_chk_err = (|w_sc_diff) && !w_wr_hit;
        w_ptr_adv = !w_chk_err;
      end
      FIX: begin
        w_wr_ready = 1'b0;
        w_fix_we   = 1'b1;
        w_ptr_adv  = 1'b1;
      end
      default: ;
    endcase
  end

  // Injection is applied last so it lands on top of a write or a FIX writeback.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_mem_nxt[k] = r_mem[k];
      if (w_wr_fire) w_mem_nxt[k][bus.wr_addr_i] = bus.wr_data_i;
      if (w_fix_we)  w_mem_nxt[k][r_ptr] = r_fix_word;
      if (bus.inj_en_i && bus.inj_copy_i == 2'(k))
        w_mem_nxt[k][bus.inj_addr_i] = w_mem_nxt[k][bus.inj_addr_i] ^ bus.inj_mask_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 3; k++) r_mem[k] <= '0;
      r_ptr      <= '0;
      r_ivl      <= '0;
      r_err      <= 1'b0;
      r_err_copy <= '0;
      r_cnt      <= '0;
      r_fix_word <= '0;
    end else begin
      for (int k = 0; k < 3; k++) r_mem[k] <= w_mem_nxt[k];
      if (r_state == IDLE && bus.scrub_en_i && r_ivl != IvlLast) r_ivl <= r_ivl + 1'b1;
      else                                                       r_ivl <= '0;
      if (w_ptr_adv) r_ptr <= (r_ptr == PtrLast) ? '0 : r_ptr + 1'b1;
      r_err <= w_chk_err;
      if (w_chk_err) begin
        r_err_copy <= w_sc_diff;
        r_fix_word <= w_sc_vote;
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tmr_scrub_regfile.sv
// Directed bench for tmr_scrub_regfile: per-copy reference model plus queues of expected
// read results and expected scrub corrections.
module tb_tmr_scrub_regfile;
  localparam int DW = 32, NW = 8, SI = 4, CW = 16, AW = 3;

  typedef struct { logic [AW-1:0] addr; logic [2:0] copies; logic [CW-1:0] cnt; } err_exp_t;
  typedef struct { logic [DW-1:0] data; logic mis; } rd_exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  tmr_scrub_regfile_if #(.DataWidth(DW), .NumWords(NW), .CntWidth(CW)) bus();
  tmr_scrub_regfile #(.DataWidth(DW), .NumWords(NW), .ScrubInterval(SI), .CntWidth(CW))
    dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  int n_vec = 0, n_fail = 0;
  logic [DW-1:0] m [3][NW];
  err_exp_t errq[$];
  rd_exp_t  rdq[$];
  err_exp_t mon_e;
  logic [DW-1:0] mon_v;
  logic prev_err = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] maj(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [DW-1:0] c);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) for (int a = 0; a < NW; a++) m[k][a] = '0;
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_valid_i = 1'b1; bus.wr_addr_i = a; bus.wr_data_i = d;
    #1 chk("wr_ready", bus.wr_ready_o, 1);
    step();
    bus.wr_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) m[k][a] = d;
  endtask

  task automatic inj(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] msk);
    bus.inj_en_i = 1'b1; bus.inj_copy_i = c; bus.inj_addr_i = a; bus.inj_mask_i = msk;
    step();
    bus.inj_en_i = 1'b0;
    m[c][a] = m[c][a] ^ msk;
  endtask

  task automatic rd_chk(input logic [AW-1:0] a, input string tag);
    rd_exp_t e;
    rdq.push_back('{maj(m[0][a], m[1][a], m[2][a]), (m[0][a] != m[1][a]) || (m[1][a] != m[2][a])});
    bus.rd_addr_i = a;
    #1;
    e = rdq.pop_front();
    chk({tag, "_data"}, bus.rd_data_o, e.data);
    chk({tag, "_mis"}, bus.rd_mismatch_o, e.mis);
  endtask

  task automatic wait_err(input int bound);
    logic found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_i);
      if (bus.err_o) begin found = 1'b1; break; end
    end
    chk("err_wait", found, 1);
  endtask

  // Every scrub correction must match the head of the expected queue; FIX stalls writes.
  always @(negedge clk_i) begin
    if (!rst_i && bus.err_o) begin
      chk("err_single_pulse", prev_err, 0);
      chk("fix_wr_ready", bus.wr_ready_o, 0);
      if (errq.size() == 0) chk("err_unexpected", bus.err_o, 0);
      else begin
        mon_e = errq.pop_front();
        chk("err_copy", bus.err_copy_o, mon_e.copies);
        chk("err_cnt", bus.err_cnt_o, mon_e.cnt);
        mon_v = maj(m[0][mon_e.addr], m[1][mon_e.addr], m[2][mon_e.addr]);
        for (int k = 0; k < 3; k++) m[k][mon_e.addr] = mon_v;
      end
    end
    prev_err = bus.err_o;
  end

  initial begin
    bus.wr_valid_i = 0; bus.wr_addr_i = '0; bus.wr_data_i = '0; bus.rd_addr_i = '0;
    bus.scrub_en_i = 0; bus.inj_en_i = 0; bus.inj_copy_i = '0; bus.inj_addr_i = '0;
    bus.inj_mask_i = '0;
    model_clear();
    step(); step();
    rst_i = 1'b0;

    // reset state
    chk("rst_err", bus.err_o, 0);
    chk("rst_err_copy", bus.err_copy_o, 0);
    chk("rst_err_cnt", bus.err_cnt_o, 0);
    chk("rst_wr_ready", bus.wr_ready_o, 1);
    for (int a = 0; a < NW; a++) rd_chk(AW'(a), "rst_rd");

    // write fans out to all copies, visible next cycle
    wr(3, 32'hDEADBEEF);
    for (int a = 0; a < NW; a++) rd_chk(AW'(a), "wr_rd");

    // single-copy fault is masked by the vote, no scrub without enable
    wr(5, 32'h0);
    inj(1, 5, 32'h0000_00FF);
    rd_chk(5, "inj1_rd");
    repeat (10) step();
    chk("cnt_scrub_off", bus.err_cnt_o, 0);

    // scrubber finds and repairs addr 5
    errq.push_back('{3'd5, 3'b010, 16'd1});
    bus.scrub_en_i = 1'b1;
    wait_err(200);
    step();
    rd_chk(5, "fix5_rd");
    chk("err_copy_held", bus.err_copy_o, 3'b010);

    // two copies hit with disjoint masks at addr 0
    bus.scrub_en_i = 1'b0;
    step(); step();
    inj(0, 0, 32'h1);
    inj(2, 0, 32'h2);
    rd_chk(0, "inj02_rd");
    errq.push_back('{3'd0, 3'b101, 16'd2});
    bus.scrub_en_i = 1'b1;
    wait_err(200);
    step();
    rd_chk(0, "fix0_rd");
    repeat (60) step();
    rd_chk(0, "clean_pass_rd");

    // fault-free scrubbing across the wrap with random writes never stalled
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 1) == 1) wr(AW'($urandom_range(0, NW - 1)), $urandom);
      else step();
    end
    for (int a = 0; a < NW; a++) rd_chk(AW'(a), "wrap_rd");
    chk("wrap_cnt", bus.err_cnt_o, 2);

    // reset in the middle of FIX
    inj(2, 4, 32'h0000_F0F0);
    errq.push_back('{3'd4, 3'b100, 16'd3});
    wait_err(200);
    #1 rst_i = 1'b1;
    bus.scrub_en_i = 1'b0;
    model_clear();
    step(); step();
    rst_i = 1'b0;
    for (int a = 0; a < NW; a++) rd_chk(AW'(a), "rst_fix_rd");
    chk("rst_fix_cnt", bus.err_cnt_o, 0);
    chk("rst_fix_copy", bus.err_copy_o, 0);
    chk("rst_fix_err", bus.err_o, 0);
    chk("rst_fix_ready", bus.wr_ready_o, 1);

    // restart from IDLE with pointer 0: addr 0 checked after exactly SI idle cycles
    inj(0, 0, 32'h8000_0000);
    errq.push_back('{3'd0, 3'b001, 16'd1});
    bus.scrub_en_i = 1'b1;
    repeat (SI) @(posedge clk_i);
    @(negedge clk_i);
    chk("restart_early", bus.err_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("restart_ptr0", bus.err_o, 1);
    step();
    rd_chk(0, "restart_rd");
    bus.scrub_en_i = 1'b0;
    repeat (3) step();

    chk("errq_drained", 32'(errq.size()), 0);
    chk("rdq_drained", 32'(rdq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/tmr_scrub_regfile.md
Name: tmr_scrub_regfile

Overview:
- Triplicated register file: every write fans out to three copies.
- Reads return the bitwise majority vote of the three copies.
- A background scrubber walks the words, detects divergent copies, rewrites them with the voted value and counts corrections.
- Includes a fault-injection port so the TMR voting path can be exercised in simulation and on FPGA.

Parameters:
- DataWidth, 32, bits per word.
- NumWords, 8, words per copy; must be >= 2. Address width is AddrW = clog2(NumWords).
- ScrubInterval, 16, idle cycles between scrub checks; must be >= 1.
- CntWidth, 16, width of the saturating correction counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  write accepted when wr_valid_i && wr_ready_o.
- wr_addr_i  in  AddrW  write address.
- wr_data_i  in  DataWidth  write data.
- rd_addr_i  in  AddrW  read address.
- rd_data_o  out  DataWidth  voted read data, combinational.
- rd_mismatch_o  out  1  copies at rd_addr_i not all equal, combinational.
- scrub_en_i  in  1  enable background scrubbing.
- inj_en_i  in  1  fault-injection strobe.
- inj_copy_i  in  2  target copy, 0..2; value 3 is ignored.
- inj_addr_i  in  AddrW  injection address.
- inj_mask_i  in  DataWidth  XOR mask.
- err_o  out  1  one-cycle pulse when the scrubber detects a mismatch.
- err_copy_o  out  3  bit k set = copy k disagreed with the vote; held until the next err_o.
- err_cnt_o  out  CntWidth  saturating count of detected mismatches.

Behaviour:
- Reset, synchronous, active-high:
  - All copies become 0; scrub pointer 0; interval counter 0; FSM in IDLE.
  - err_o=0, err_copy_o=0, err_cnt_o=0, wr_ready_o=1.
  - Reset mid-CHECK or mid-FIX aborts the operation with no writeback and no count.
- Read path:
  - rd_data_o = (a&b)|(a&c)|(b&c), per bit, on the three copies at rd_addr_i.
  - Zero latency. A write accepted in cycle N is visible on reads in cycle N+1.
- Write path:
  - An accepted write stores wr_data_i into all three copies at wr_addr_i at the clock edge.
  - wr_ready_o=0 only in the FIX state; it is 1 in all other states.
- Injection:
  - On inj_en_i, the target copy's next value at inj_addr_i is XORed with inj_mask_i.
  - The XOR applies on top of any same-cycle write or FIX writeback to that address, so injection always wins.
  - Injection is never blocked.
- FSM states: IDLE, CHECK, FIX.
  - IDLE: while scrub_en_i=1 the interval counter increments. When it equals ScrubInterval-1, clear it and go to CHECK. If scrub_en_i=0, the counter is held at 0.
  - CHECK (1 cycle): compare the three copies at the scrub pointer.
    - All equal: pointer+1 (wraps NumWords-1 -> 0); go to IDLE.
    - Any mismatch: err_o=1; err_copy_o = per-copy (copy != voted) mask; err_cnt_o+1, saturating at all-ones; capture the voted word; go to FIX.
    - If a write is accepted to the pointer address in the same cycle: no error reported, no count; pointer+1; go to IDLE.
  - FIX (1 cycle): write the captured voted word into all three copies at the pointer; pointer+1 with wrap; go to IDLE.
- Deasserting scrub_en_i during CHECK or FIX lets the current operation complete. The FSM then stays in IDLE.
- Only one scrub operation is in flight at a time; the maximum scrub rate is one word per ScrubInterval+1 cycles (clean word) or ScrubInterval+2 cycles (corrected word).

Test Plan:
- Reset, then write 0xDEADBEEF to addr 3 -> next cycle rd_data_o=0xDEADBEEF, rd_mismatch_o=0 at addr 3; all other addrs read 0.
- Write 0x0 to addr 5, then inject copy 1 with mask 0x000000FF at addr 5, scrub_en_i=0 -> rd_data_o=0x0, rd_mismatch_o=1; err_cnt_o stays 0.
- Same state, then scrub_en_i=1, ScrubInterval=4 -> when the pointer reaches 5: err_o pulses once, err_copy_o=3'b010, err_cnt_o=1. In the FIX cycle wr_ready_o=0. Afterwards rd_mismatch_o=0 at addr 5.
- Inject copies 0 and 2 with disjoint masks 0x1 and 0x2 at addr 0, scrub enabled -> rd_data_o stays correct; one err_o with err_copy_o=3'b101; the next pass over addr 0 is clean.
- Pointer wrap: with NumWords=8, scrub runs over more than 8 checks with no faults -> the pointer goes 7 -> 0, err_o never pulses, and writes to random addresses are never stalled outside FIX.
- Assert rst_i during FIX of a corrupted word -> all copies read 0; err_cnt_o=0; the FSM restarts in IDLE with pointer 0.
